avr_io_arbiter: RTL and testbench

- Shares the CPU's 64-location IO space between two masters: the CPU exec stage (m0) and a debug/DMA port (m1).
- Inserts wait states by stalling the CPU through its hold input, and supports slow peripherals through an io_ready handshake.
- Sits between the CPU top level, where the io_data tristate is split into wdata/rdata, and the peripheral IO decoder.

---
 rtl/avr_io_pkg.sv | 12 +
 rtl/avr_io_age_counter.sv | 30 +++
 rtl/avr_io_arbiter.sv | 133 +++++++++++++
 tb/tb_avr_io_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/avr_io_pkg.sv
// Shared types and constants for the AVR IO-space arbiter.
package avr_io_pkg;
   localparam int IO_ADDR_W = 6;
   localparam int IO_DATA_W = 8;
   localparam logic [IO_DATA_W-1:0] IO_RDATA_ERR = 8'hFF;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CPU_BUSY = 2'd1,
      DBG_BUSY = 2'd2
   } io_state_e;
endpackage

// File: rtl/avr_io_age_counter.sv
// Saturating up-counter with synchronous clear and a ">= THRESH" flag.
module avr_io_age_counter
   import avr_io_pkg::*;
#(
   parameter int CNT_W  = 8,
   parameter int THRESH = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic hit
);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + CNT_W'(1);
      end
   end

   assign hit = (count >= THRESH_V);
endmodule

// File: rtl/avr_io_arbiter.sv
// Two-master arbiter for the 64-location AVR IO space (CPU exec stage and debug/DMA port).
// Define AVR_IO_TIMEOUT_EN to abort accesses that never see io_ready.
//
// state    | meaning
// IDLE     | no access in flight; grant decided combinationally, zero-wait accesses finish here
// CPU_BUSY | CPU access waiting for io_ready, CPU held
// DBG_BUSY | debug access waiting for io_ready
module avr_io_arbiter
   import avr_io_pkg::*;
#(
   parameter int ADDR_W   = IO_ADDR_W,
   parameter int DATA_W   = IO_DATA_W,
   parameter int MAX_WAIT = 8,
   parameter int TIMEOUT  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] cpu_io_addr,
   input  logic [DATA_W-1:0] cpu_io_wdata,
   input  logic              cpu_io_read,
   input  logic              cpu_io_write,
   output logic [DATA_W-1:0] cpu_io_rdata,
   output logic              cpu_hold,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   input  logic              dbg_we,
   input  logic              dbg_req,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [ADDR_W-1:0] io_addr,
   output logic [DATA_W-1:0] io_wdata,
   output logic              io_read,
   output logic              io_write,
   input  logic [DATA_W-1:0] io_rdata,
   input  logic              io_ready,
   output logic              bus_err
);
   localparam logic [DATA_W-1:0] RDATA_ERR = DATA_W'(IO_RDATA_ERR);

   if (MAX_WAIT < 1 || MAX_WAIT > 255 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_check
      $error("avr_io_arbiter: MAX_WAIT or TIMEOUT out of range");
   end

   io_state_e state, state_nxt;
   logic      cpu_req, cpu_own, dbg_own, done, tmo, dbg_force;

   assign cpu_req = cpu_io_read | cpu_io_write;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      cpu_own = 1'b0;
      dbg_own = 1'b0;
      case (state)
         IDLE: begin
            cpu_own = cpu_req & ~dbg_force;
            dbg_own = ~cpu_own & dbg_req;
         end
         CPU_BUSY: cpu_own = 1'b1;
         DBG_BUSY: dbg_own = 1'b1;
         default: ;
      endcase
   end

`ifdef AVR_IO_TIMEOUT_EN
   // Fires on the (TIMEOUT-1)th BUSY cycle: count holds the number of BUSY cycles already spent.
   logic tmo_hit;
   avr_io_age_counter #(.CNT_W(8), .THRESH(TIMEOUT-2)) u_tmo (
      .clk (clk),
      .rst (rst),
      .clr (state == IDLE),
      .inc (state != IDLE),
      .hit (tmo_hit)
   );
   assign tmo = (state != IDLE) & tmo_hit;
`else
   assign tmo = 1'b0;
`endif

   assign done = io_ready | tmo;

   // Outputs are gated by rst so strobes fall the moment reset asserts, not at the next edge.
   always_comb begin
      io_addr      = '0;
      io_wdata     = '0;
      io_read      = 1'b0;
      io_write     = 1'b0;
      cpu_hold     = 1'b0;
      cpu_io_rdata = '0;
      dbg_ack      = 1'b0;
      dbg_rdata    = '0;
      bus_err      = 1'b0;
      state_nxt    = state;
      if (rst) begin
         if (cpu_own) begin
            io_addr  = cpu_io_addr;
            io_wdata = cpu_io_wdata;
            io_read  = cpu_io_read;
            io_write = cpu_io_write;
         end else if (dbg_own) begin
            io_addr  = dbg_addr;
            io_wdata = dbg_wdata;
            io_read  = ~dbg_we;
            io_write = dbg_we;
         end
         cpu_hold = cpu_req & ~(cpu_own & done);
         if (cpu_own && done) cpu_io_rdata = tmo ? RDATA_ERR : io_rdata;
         if (dbg_own && done) begin
            dbg_ack   = 1'b1;
            dbg_rdata = tmo ? RDATA_ERR : io_rdata;
         end
         bus_err = tmo;
         case (state)
            IDLE: begin
               if (cpu_own && !done)      state_nxt = CPU_BUSY;
               else if (dbg_own && !done) state_nxt = DBG_BUSY;
            end
            default: if (done) state_nxt = IDLE;
         endcase
      end
   end

   avr_io_age_counter #(.CNT_W(8), .THRESH(MAX_WAIT)) u_age (
      .clk (clk),
      .rst (rst),
      .clr (dbg_ack | ~dbg_req),
      .inc (dbg_req & ~dbg_own),
      .hit (dbg_force)
   );
endmodule

// File: tb/tb_avr_io_arbiter.sv
// Directed self-checking bench for avr_io_arbiter (timeout case only when AVR_IO_TIMEOUT_EN is defined).
module tb_avr_io_arbiter;
   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] cpu_io_addr, dbg_addr, io_addr;
   logic [7:0] cpu_io_wdata, cpu_io_rdata, dbg_wdata, dbg_rdata, io_wdata, io_rdata;
   logic       cpu_io_read, cpu_io_write, cpu_hold;
   logic       dbg_we, dbg_req, dbg_ack;
   logic       io_read, io_write, io_ready, bus_err;

   int n_checks = 0;
   int n_errors = 0;

   avr_io_arbiter #(.ADDR_W(6), .DATA_W(8), .MAX_WAIT(8), .TIMEOUT(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .cpu_io_addr  (cpu_io_addr),
      .cpu_io_wdata (cpu_io_wdata),
      .cpu_io_read  (cpu_io_read),
      .cpu_io_write (cpu_io_write),
      .cpu_io_rdata (cpu_io_rdata),
      .cpu_hold     (cpu_hold),
      .dbg_addr     (dbg_addr),
      .dbg_wdata    (dbg_wdata),
      .dbg_we       (dbg_we),
      .dbg_req      (dbg_req),
      .dbg_ack      (dbg_ack),
      .dbg_rdata    (dbg_rdata),
      .io_addr      (io_addr),
      .io_wdata     (io_wdata),
      .io_read      (io_read),
      .io_write     (io_write),
      .io_rdata     (io_rdata),
      .io_ready     (io_ready),
      .bus_err      (bus_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int hold_cnt, wr_cnt, ack_cyc, hold_before, rel_cyc, err_early;
      logic hold_at_ack, wr_at_ack, err_at_rel;
      logic [5:0] addr_at_ack;
      logic [7:0] rd_at_rel;

      rst = 1'b0;
      cpu_io_addr = 6'h3F; cpu_io_wdata = 8'h00; cpu_io_read = 1'b1; cpu_io_write = 1'b0;
      dbg_addr = 6'h00; dbg_wdata = 8'h00; dbg_we = 1'b0; dbg_req = 1'b0;
      io_rdata = 8'hA5; io_ready = 1'b1;

      // reset: outputs forced low even with a CPU request present
      #12;
      check("rst_io_read", io_read, 0);
      check("rst_cpu_hold", cpu_hold, 0);
      check("rst_cpu_rdata", cpu_io_rdata, 0);
      check("rst_io_addr", io_addr, 0);
      check("rst_state", int'(dut.state), 0);
      check("rst_age", dut.u_age.count, 0);
      cpu_io_read = 1'b0;
      next_cycle;
      rst = 1'b1;

      // zero-wait CPU read of 0x3F
      next_cycle;
      cpu_io_addr = 6'h3F; cpu_io_read = 1'b1; io_ready = 1'b1; io_rdata = 8'hA5;
      #3;
      check("rd0_rdata", cpu_io_rdata, 8'hA5);
      check("rd0_hold", cpu_hold, 0);
      check("rd0_io_read", io_read, 1);
      check("rd0_io_addr", io_addr, 6'h3F);
      next_cycle;
      cpu_io_read = 1'b0;
      #3;
      check("rd0_io_read_after", io_read, 0);
      check("rd0_state", int'(dut.state), 0);

      // CPU write with io_ready three cycles late
      next_cycle;
      cpu_io_addr = 6'h05; cpu_io_wdata = 8'h12; cpu_io_write = 1'b1;
      hold_cnt = 0; wr_cnt = 0;
      for (int c = 0; c < 4; c++) begin
         io_ready = (c == 3);
         #3;
         hold_cnt += int'(cpu_hold);
         wr_cnt   += int'(io_write);
         check("wr_addr", io_addr, 6'h05);
         check("wr_wdata", io_wdata, 8'h12);
         check("wr_bus_err", bus_err, 0);
         next_cycle;
      end
      cpu_io_write = 1'b0; io_ready = 1'b0;
      #3;
      check("wr_hold_cycles", hold_cnt, 3);
      check("wr_write_cycles", wr_cnt, 4);
      check("wr_state_idle", int'(dut.state), 0);
      check("wr_io_write_after", io_write, 0);

      // simultaneous CPU read and debug read: CPU first
      next_cycle;
      cpu_io_addr = 6'h20; cpu_io_read = 1'b1;
      dbg_addr = 6'h10; dbg_we = 1'b0; dbg_req = 1'b1;
      io_ready = 1'b1; io_rdata = 8'h5A;
      #3;
      check("sim_cpu_addr", io_addr, 6'h20);
      check("sim_cpu_hold", cpu_hold, 0);
      check("sim_ack_c0", dbg_ack, 0);
      next_cycle;
      cpu_io_read = 1'b0;
      #3;
      check("sim_dbg_addr", io_addr, 6'h10);
      check("sim_ack_c1", dbg_ack, 1);
      check("sim_dbg_rdata", dbg_rdata, 8'h5A);
      next_cycle;
      dbg_req = 1'b0;
      #3;
      check("sim_ack_c2", dbg_ack, 0);

      // CPU hogs the bus; debug forced in after MAX_WAIT cycles
      next_cycle;
      cpu_io_addr = 6'h22; cpu_io_read = 1'b1; io_ready = 1'b1; io_rdata = 8'h77;
      dbg_addr = 6'h07; dbg_wdata = 8'h33; dbg_we = 1'b1; dbg_req = 1'b1;
      ack_cyc = -1; hold_before = 0; hold_at_ack = 1'b0; wr_at_ack = 1'b0; addr_at_ack = '0;
      for (int c = 0; c < 20; c++) begin
         #3;
         if (dbg_ack) begin
            ack_cyc = c; hold_at_ack = cpu_hold; wr_at_ack = io_write; addr_at_ack = io_addr;
            next_cycle;
            break;
         end
         hold_before += int'(cpu_hold);
         next_cycle;
      end
      dbg_req = 1'b0;
      #3;
      check("age_ack_cycle", ack_cyc, 8);
      check("age_hold_before", hold_before, 0);
      check("age_hold_at_ack", hold_at_ack, 1);
      check("age_write_at_ack", wr_at_ack, 1);
      check("age_addr_at_ack", addr_at_ack, 6'h07);
      check("age_count_cleared", dut.u_age.count, 0);
      check("age_cpu_served_again", io_addr, 6'h22);
      check("age_cpu_hold_after", cpu_hold, 0);
      next_cycle;
      cpu_io_read = 1'b0;

      // reset during DBG_BUSY
      next_cycle;
      dbg_addr = 6'h11; dbg_we = 1'b0; dbg_req = 1'b1; io_ready = 1'b0;
      #3;
      check("rbusy_grant_read", io_read, 1);
      next_cycle;
      check("rbusy_state", int'(dut.state), 2);
      check("rbusy_io_read", io_read, 1);
      rst = 1'b0;
      #1;
      check("rbusy_io_read_drop", io_read, 0);
      check("rbusy_io_write_drop", io_write, 0);
      check("rbusy_ack_low", dbg_ack, 0);
      check("rbusy_state_idle", int'(dut.state), 0);
      dbg_req = 1'b0;
      next_cycle;
      rst = 1'b1; io_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #3;
         check("rbusy_no_spurious_ack", dbg_ack, 0);
         check("rbusy_idle_read", io_read, 0);
         next_cycle;
      end

`ifdef AVR_IO_TIMEOUT_EN
      // io_ready stuck low on a CPU read: aborted on the 15th BUSY cycle
      cpu_io_addr = 6'h01; cpu_io_read = 1'b1; io_ready = 1'b0;
      rel_cyc = -1; err_early = 0; rd_at_rel = '0; err_at_rel = 1'b0;
      for (int c = 0; c < 40; c++) begin
         #3;
         if (!cpu_hold) begin
            rel_cyc = c; rd_at_rel = cpu_io_rdata; err_at_rel = bus_err;
            next_cycle;
            break;
         end
         err_early += int'(bus_err);
         next_cycle;
      end
      cpu_io_read = 1'b0;
      #3;
      check("tmo_release_cycle", rel_cyc, 15);
      check("tmo_rdata", rd_at_rel, 8'hFF);
      check("tmo_bus_err", err_at_rel, 1);
      check("tmo_err_early", err_early, 0);
      check("tmo_bus_err_after", bus_err, 0);
      check("tmo_state_idle", int'(dut.state), 0);
`else
      hold_cnt = 0; wr_cnt = 0; rel_cyc = 0; err_early = 0;
      rd_at_rel = '0; err_at_rel = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
